f1_start_ctrl: RTL and testbench

Sequencing controller for the F1 start-light datapath. It gates the tick generator's enable and steps an 8-light thermometer bar one light per tick. It holds all lights on for a pseudo-random number of ticks, then switches them off and measures the driver's reaction time in clock cycles. It sits between the top-level push-buttons and the tick generator / light display, replacing the free-running light FSM.

---
 rtl/f1_start_ctrl.sv | 123 ++++++++++++
 tb/tb_f1_start_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_ctrl.sv
// +--------------------------------------------------------------------------+
// | f1_start_ctrl: F1 start-light sequencer, random hold, reaction timer.    |
// | Optional macro F1_TIMEOUT_EN: abandon OUT when the reaction counter      |
// | saturates. Revision: 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module f1_start_ctrl #(
  parameter int LIGHTS = 8,
  parameter int LFSR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              tick,
  input  logic              react,
  output logic              tick_en,
  output logic [LIGHTS-1:0] lights,
  output logic              busy,
  output logic [CNT_W-1:0]  react_time,
  output logic              time_valid,
  output logic              jump_start
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    HOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [LIGHTS-1:0] ALL_ON   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [LFSR_W:0]   HOLD_ONE = 1;

  state_t              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W:0]     hold_cnt;   // one bit wider so lfsr + 1 can reach 2^LFSR_W
  logic [CNT_W-1:0]    react_cnt;
  logic [LIGHTS-1:0]   lights_next;

  assign lights_next = {lights[LIGHTS-2:0], 1'b1};

  // Straight decodes of the state register keep these free of input paths.
  assign tick_en = (state == SEQ) || (state == HOLD);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= {{(LFSR_W-1){1'b0}}, 1'b1};
      hold_cnt   <= '0;
      react_cnt  <= '0;
      lights     <= '0;
      react_time <= '0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      lfsr       <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
      time_valid <= 1'b0;
      jump_start <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state  <= SEQ;
            lights <= '0;
          end
        end
        SEQ: begin
          if (react) begin
            state      <= IDLE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            lights <= lights_next;
            if (lights_next == ALL_ON) begin
              state    <= HOLD;
              hold_cnt <= {1'b0, lfsr} + HOLD_ONE;
            end
          end
        end
        HOLD: begin
          if (react) begin
            state      <= IDLE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (hold_cnt == HOLD_ONE) begin
              state     <= OUT;
              lights    <= '0;
              react_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
        end
        OUT: begin
          if (react) begin
            state      <= IDLE;
            react_time <= react_cnt;
            time_valid <= 1'b1;
          end else if (react_cnt == CNT_MAX) begin
`ifdef F1_TIMEOUT_EN
            state      <= IDLE;
            react_time <= CNT_MAX;
            time_valid <= 1'b1;
`else
            react_cnt  <= CNT_MAX;
`endif
          end else begin
            react_cnt <= react_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_f1_start_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_f1_start_ctrl: self-checking bench for f1_start_ctrl (CNT_W = 8).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_f1_start_ctrl;

  localparam int LIGHTS = 8;
  localparam int LFSR_W = 7;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic              tick = 1'b0;
  logic              react = 1'b0;
  logic              tick_en;
  logic [LIGHTS-1:0] lights;
  logic              busy;
  logic [CNT_W-1:0]  react_time;
  logic              time_valid;
  logic              jump_start;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [CNT_W-1:0]  exp_q[$];
  logic [LIGHTS-1:0] lq[$];
  logic [CNT_W-1:0]  last_rt;
  logic [LFSR_W-1:0] m_lfsr;

  f1_start_ctrl #(.LIGHTS(LIGHTS), .LFSR_W(LFSR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .react(react),
    .tick_en(tick_en), .lights(lights), .busy(busy), .react_time(react_time),
    .time_valid(time_valid), .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^7 + x^6 Fibonacci, seeded with 1 at reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One-cycle tick; v is the LFSR value the DUT sees at the sampling edge.
  task automatic do_tick(output logic [LFSR_W-1:0] v);
    tick = 1'b1;
    v = m_lfsr;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic run_seq(output logic [LFSR_W-1:0] v);
    for (int i = 0; i < LIGHTS; i++) begin cyc(1); do_tick(v); end
  endtask

  task automatic run_hold(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] d;
    for (int j = 0; j <= int'(v); j++) begin cyc(1); do_tick(d); end
  endtask

  task automatic wait_tv(input int budget, output bit seen);
    int n = 0;
    while (n < budget && time_valid !== 1'b1) begin cyc(1); n++; end
    seen = (time_valid === 1'b1);
  endtask

  task automatic test_reset;
    cyc(2);
    chk_cnt++; if (lights !== 8'h00) $display("FAIL reset_lights got %h want 00", lights); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (tick_en !== 1'b0) $display("FAIL reset_tick_en got %b want 0", tick_en); else pass_cnt++;
    chk_cnt++; if (react_time !== 8'h00) $display("FAIL reset_react_time got %h want 00", react_time); else pass_cnt++;
    chk_cnt++; if ({time_valid, jump_start} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {time_valid, jump_start}); else pass_cnt++;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_sequence;
    logic [LFSR_W-1:0] v, d;
    logic [LIGHTS-1:0] exp_l, got_l;
    bit seen;
    trigger = 1'b1; cyc(1); trigger = 1'b0;
    chk_cnt++; if ({busy, tick_en, lights} !== {2'b11, 8'h00}) $display("FAIL seq_start got busy=%b tick_en=%b lights=%h want 1 1 00", busy, tick_en, lights); else pass_cnt++;
    exp_l = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      cyc(4);
      exp_l = {exp_l[LIGHTS-2:0], 1'b1};
      lq.push_back(exp_l);
      do_tick(v);
      got_l = lq.pop_front();
      chk_cnt++; if (lights !== got_l || tick_en !== 1'b1) $display("FAIL seq_step%0d got lights=%h tick_en=%b want %h 1", i, lights, tick_en, got_l); else pass_cnt++;
    end
    for (int j = 0; j < int'(v); j++) begin cyc(1); do_tick(d); end
    chk_cnt++; if (lights !== 8'hFF || tick_en !== 1'b1) $display("FAIL hold_early got lights=%h tick_en=%b want FF 1 (v=%0d)", lights, tick_en, v); else pass_cnt++;
    cyc(1); do_tick(d);
    chk_cnt++; if ({lights, busy, tick_en} !== {8'h00, 2'b10}) $display("FAIL lights_out got lights=%h busy=%b tick_en=%b want 00 1 0", lights, busy, tick_en); else pass_cnt++;
    cyc(37);
    react = 1'b1; exp_q.push_back(8'd37);
    cyc(1); react = 1'b0;
    wait_tv(4, seen);
    chk_cnt++; if (!seen) $display("FAIL react_tv got no time_valid want pulse"); else pass_cnt++;
    chk_cnt++; if (react_time !== exp_q[0]) $display("FAIL react_time got %0d want %0d", react_time, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    cyc(1);
    chk_cnt++; if (time_valid !== 1'b0 || busy !== 1'b0) $display("FAIL tv_width got tv=%b busy=%b want 0 0", time_valid, busy); else pass_cnt++;
    last_rt = 8'd37;
  endtask

  task automatic test_jump_start;
    logic [LFSR_W-1:0] d;
    trigger = 1'b1; cyc(1); trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(1); do_tick(d); end
    cyc(1);
    react = 1'b1; do_tick(d); react = 1'b0;
    chk_cnt++; if (lights !== 8'h00) $display("FAIL jump_lights got %h want 00", lights); else pass_cnt++;
    chk_cnt++; if ({jump_start, time_valid, busy, tick_en} !== 4'b1000) $display("FAIL jump_flags got js/tv/busy/te=%b want 1000", {jump_start, time_valid, busy, tick_en}); else pass_cnt++;
    chk_cnt++; if (react_time !== last_rt) $display("FAIL jump_react_time got %0d want %0d", react_time, last_rt); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (jump_start !== 1'b0) $display("FAIL jump_width got %b want 0", jump_start); else pass_cnt++;
  endtask

  task automatic test_trigger_held;
    logic [LFSR_W-1:0] v, d;
    bit seen;
    trigger = 1'b1; cyc(1);
    run_seq(v);
    run_hold(v);
    cyc(3);
    react = 1'b1; exp_q.push_back(8'd3);
    cyc(1); react = 1'b0;
    wait_tv(1, seen);
    chk_cnt++; if (!seen || busy !== 1'b0 || react_time !== exp_q[0]) $display("FAIL held_done got tv=%b busy=%b rt=%0d want 1 0 %0d", time_valid, busy, react_time, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    last_rt = 8'd3;
    cyc(1);
    chk_cnt++; if ({busy, tick_en, lights} !== {2'b11, 8'h00}) $display("FAIL held_restart got busy=%b tick_en=%b lights=%h want 1 1 00", busy, tick_en, lights); else pass_cnt++;
    trigger = 1'b0; cyc(2);
    trigger = 1'b1; cyc(1); trigger = 1'b0;
    do_tick(d);
    chk_cnt++; if (lights !== 8'h01 || busy !== 1'b1) $display("FAIL seq_trigger_ignored got lights=%h busy=%b want 01 1", lights, busy); else pass_cnt++;
    react = 1'b1; cyc(1); react = 1'b0;
    chk_cnt++; if ({jump_start, busy, react_time} !== {2'b10, last_rt}) $display("FAIL held_exit got js=%b busy=%b rt=%0d want 1 0 %0d", jump_start, busy, react_time, last_rt); else pass_cnt++;
    cyc(1);
  endtask

  task automatic test_timeout;
    logic [LFSR_W-1:0] v;
    bit seen;
    trigger = 1'b1; cyc(1); trigger = 1'b0;
    run_seq(v);
    run_hold(v);
    exp_q.push_back(8'hFF);
`ifdef F1_TIMEOUT_EN
    wait_tv(400, seen);
`else
    cyc(300);
    chk_cnt++; if ({busy, tick_en, time_valid} !== 3'b100) $display("FAIL out_wait got busy/te/tv=%b want 100", {busy, tick_en, time_valid}); else pass_cnt++;
    react = 1'b1; cyc(1); react = 1'b0;
    wait_tv(1, seen);
`endif
    chk_cnt++; if (!seen) $display("FAIL timeout_tv got no time_valid want pulse"); else pass_cnt++;
    chk_cnt++; if (react_time !== exp_q[0] || busy !== 1'b0) $display("FAIL timeout_rt got rt=%h busy=%b want %h 0", react_time, busy, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    cyc(1);
  endtask

  task automatic test_reset_mid;
    logic [LFSR_W-1:0] v;
    trigger = 1'b1; cyc(1); trigger = 1'b0;
    run_seq(v);
    chk_cnt++; if (lights !== 8'hFF || tick_en !== 1'b1) $display("FAIL pre_reset got lights=%h tick_en=%b want FF 1", lights, tick_en); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    chk_cnt++; if ({lights, busy, tick_en} !== {8'h00, 2'b00}) $display("FAIL async_reset got lights=%h busy=%b te=%b want 00 0 0", lights, busy, tick_en); else pass_cnt++;
    chk_cnt++; if ({time_valid, jump_start, react_time} !== {2'b00, 8'h00}) $display("FAIL async_reset_out got tv=%b js=%b rt=%h want 0 0 00", time_valid, jump_start, react_time); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_jump_start;
    test_trigger_held;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
